// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit and the ALU it drives.
package mc_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtypeEx,
    StAluWb,
    StAddiEx,
    StAddiWb,
    StBranch,
    StJump
  } state_e;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes, instruction bits [5:0]
  localparam logic [5:0] FunctAdd  = 6'b100000;
  localparam logic [5:0] FunctSub  = 6'b100010;
  localparam logic [5:0] FunctSll  = 6'b000000;
  localparam logic [5:0] FunctSllv = 6'b000100;
  localparam logic [5:0] FunctSrav = 6'b000111;

  // ALUSel codes, shared with the ALU
  localparam logic [2:0] AluAdd  = 3'b010;
  localparam logic [2:0] AluSub  = 3'b110;
  localparam logic [2:0] AluSll  = 3'b011;
  localparam logic [2:0] AluSllv = 3'b100;
  localparam logic [2:0] AluSrav = 3'b101;

  // ALUOp between controller and alu_decoder
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALUSrcB mux selects
  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // PCSrc mux selects
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode: maps ALUOp and the R-type funct field to an ALUSel code.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic [1:0] alu_op_i,
  output logic [2:0] alu_sel_o,
  output logic       funct_valid_o
);

  logic [2:0] funct_sel;

  // Funct decode; valid is independent of alu_op_i so DECODE can screen R-types early
  always_comb begin
    funct_sel     = AluAdd;
    funct_valid_o = 1'b1;
    case (funct_i)
      FunctAdd:  funct_sel = AluAdd;
      FunctSub:  funct_sel = AluSub;
      FunctSll:  funct_sel = AluSll;
      FunctSllv: funct_sel = AluSllv;
      FunctSrav: funct_sel = AluSrav;
      default:   funct_valid_o = 1'b0;
    endcase
  end

  // Final operation select
  always_comb begin
    alu_sel_o = AluAdd;
    case (alu_op_i)
      AluOpSub:   alu_sel_o = AluSub;
      AluOpFunct: alu_sel_o = funct_sel;
      default:    alu_sel_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main control FSM with memory handshake and retired-instruction counter.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic [2:0]       ALUSel,
  output logic             InstrDone,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             pc_write;
  logic             branch;
  logic [1:0]       alu_op;
  logic             alu_sel_en;
  logic [2:0]       dec_sel;
  logic             funct_valid;

  alu_decoder u_alu_decoder (
    .funct_i       (Funct),
    .alu_op_i      (alu_op),
    .alu_sel_o     (dec_sel),
    .funct_valid_o (funct_valid)
  );

  // State register; synchronous reset wins from any state, including memory waits
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (InstrDone) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d    = state_q;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SrcBReg;
    PCSrc      = PcSrcAlu;
    InstrDone  = 1'b0;
    IllegalOp  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_op     = AluOpAdd;
    alu_sel_en = 1'b1;

    unique case (state_q)
      StIdle: begin
        alu_sel_en = 1'b0;
        state_d    = StFetch;
      end
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBFour;
        // IR and PC only load on the cycle the fetch completes
        IRWrite  = MemReady;
        pc_write = MemReady;
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        // Precompute branch target into ALUOut
        ALUSrcB = SrcBImmSh2;
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype: begin
            if (funct_valid) begin
              state_d = StRtypeEx;
            end else begin
              IllegalOp = 1'b1;
              state_d   = StFetch;
            end
          end
          OpAddi:  state_d = StAddiEx;
          OpBeq:   state_d = StBranch;
          OpJ:     state_d = StJump;
          default: begin
            IllegalOp = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = (Op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          InstrDone = 1'b1;
          state_d   = StFetch;
        end
      end
      StRtypeEx: begin
        ALUSrcA = 1'b1;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA   = 1'b1;
        alu_op    = AluOpSub;
        branch    = 1'b1;
        PCSrc     = PcSrcAluOut;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_write  = 1'b1;
        PCSrc     = PcSrcJump;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      default: begin
        alu_sel_en = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  // IDLE keeps every output, ALUSel included, at zero
  assign ALUSel     = alu_sel_en ? dec_sel : 3'b000;
  assign PCEn       = pc_write | (branch & Zero);
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
module tb_mc_controller;

  logic        Clk = 1'b0;
  logic        Reset, Zero, MemReady;
  logic [5:0]  Op, Funct;
  logic        IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic        PCEn, InstrDone, IllegalOp;
  logic [2:0]  ALUSel;
  logic [31:0] InstrCount;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_cnt = 32'd0;

  // Packed output view:
  // IorD MemRead MemWrite IRWrite RegWrite RegDst MemtoReg ALUSrcA ALUSrcB PCSrc PCEn ALUSel Done Ill
  localparam logic [17:0] EIdle  = 18'b0;
  localparam logic [17:0] EFetch = 18'b0_1_0_1_0_0_0_0_01_00_1_010_0_0;
  localparam logic [17:0] EFWait = 18'b0_1_0_0_0_0_0_0_01_00_0_010_0_0;
  localparam logic [17:0] EDec   = 18'b0_0_0_0_0_0_0_0_11_00_0_010_0_0;
  localparam logic [17:0] EDIll  = 18'b0_0_0_0_0_0_0_0_11_00_0_010_0_1;
  localparam logic [17:0] EMAdr  = 18'b0_0_0_0_0_0_0_1_10_00_0_010_0_0;
  localparam logic [17:0] EMRd   = 18'b1_1_0_0_0_0_0_0_00_00_0_010_0_0;
  localparam logic [17:0] EMWb   = 18'b0_0_0_0_1_0_1_0_00_00_0_010_1_0;
  localparam logic [17:0] EMWr   = 18'b1_0_1_0_0_0_0_0_00_00_0_010_0_0;
  localparam logic [17:0] EMWrD  = 18'b1_0_1_0_0_0_0_0_00_00_0_010_1_0;
  localparam logic [17:0] ERexB  = 18'b0_0_0_0_0_0_0_1_00_00_0_000_0_0;
  localparam logic [17:0] EAWb   = 18'b0_0_0_0_1_1_0_0_00_00_0_010_1_0;
  localparam logic [17:0] EAiWb  = 18'b0_0_0_0_1_0_0_0_00_00_0_010_1_0;
  localparam logic [17:0] EBr1   = 18'b0_0_0_0_0_0_0_1_00_01_1_110_1_0;
  localparam logic [17:0] EBr0   = 18'b0_0_0_0_0_0_0_1_00_01_0_110_1_0;
  localparam logic [17:0] EJmp   = 18'b0_0_0_0_0_0_0_0_00_10_1_010_1_0;

  mc_controller #(.CNT_W(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .PCEn       (PCEn),
    .ALUSel     (ALUSel),
    .InstrDone  (InstrDone),
    .IllegalOp  (IllegalOp),
    .InstrCount (InstrCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [17:0] outs();
    return {IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
            ALUSrcB, PCSrc, PCEn, ALUSel, InstrDone, IllegalOp};
  endfunction

  task automatic test_reset();
    Reset = 1'b1; MemReady = 1'b1; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    tests++;
    if (outs() !== EIdle || InstrCount !== 32'd0) begin
      fails++;
      $display("FAIL reset_hold: outs %b cnt %0d, want %b cnt 0", outs(), InstrCount, EIdle);
    end
    Reset = 1'b0; #1;
    tests++;
    if (outs() !== EIdle) begin
      fails++; $display("FAIL reset_idle: got %b want %b", outs(), EIdle);
    end
    @(posedge Clk); #1;
    tests++;
    if (outs() !== EFetch || InstrCount !== 32'd0) begin
      fails++;
      $display("FAIL reset_fetch: outs %b cnt %0d, want %b cnt 0", outs(), InstrCount, EFetch);
    end
  endtask

  task automatic test_lw();
    logic [17:0] ev [7] = '{EFetch, EDec, EMAdr, EMRd, EMRd, EMRd, EMWb};
    logic        rd [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    Op = 6'b100011; Funct = 6'b0;
    for (int i = 0; i < 7; i++) begin
      MemReady = rd[i]; #1;
      tests++;
      if (outs() !== ev[i]) begin
        fails++; $display("FAIL lw cyc%0d: got %b want %b", i, outs(), ev[i]);
      end
      @(posedge Clk); #1;
    end
    exp_cnt++;
    tests++;
    if (InstrCount !== exp_cnt) begin
      fails++; $display("FAIL lw_count: got %0d want %0d", InstrCount, exp_cnt);
    end
  endtask

  task automatic test_rtype(input logic [5:0] funct, input logic [2:0] sel);
    logic [17:0] ev [4];
    ev[0] = EFetch; ev[1] = EDec; ev[2] = ERexB | {13'b0, sel, 2'b00}; ev[3] = EAWb;
    Op = 6'b000000; Funct = funct; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (outs() !== ev[i]) begin
        fails++; $display("FAIL rtype_%b cyc%0d: got %b want %b", funct, i, outs(), ev[i]);
      end
      @(posedge Clk); #1;
    end
    exp_cnt++;
    tests++;
    if (InstrCount !== exp_cnt) begin
      fails++; $display("FAIL rtype_count: got %0d want %0d", InstrCount, exp_cnt);
    end
  endtask

  task automatic test_beq(input logic z);
    logic [17:0] ev [3];
    ev[0] = EFetch; ev[1] = EDec; ev[2] = z ? EBr1 : EBr0;
    Op = 6'b000100; Funct = 6'b0; MemReady = 1'b1; Zero = z;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (outs() !== ev[i]) begin
        fails++; $display("FAIL beq_z%0d cyc%0d: got %b want %b", z, i, outs(), ev[i]);
      end
      @(posedge Clk); #1;
    end
    Zero = 1'b0;
    exp_cnt++;
    tests++;
    if (InstrCount !== exp_cnt) begin
      fails++; $display("FAIL beq_count: got %0d want %0d", InstrCount, exp_cnt);
    end
  endtask

  task automatic test_addi();
    logic [17:0] ev [5] = '{EFWait, EFetch, EDec, EMAdr, EAiWb};
    logic        rd [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    Op = 6'b001000; Funct = 6'b101010;
    for (int i = 0; i < 5; i++) begin
      MemReady = rd[i]; #1;
      tests++;
      if (outs() !== ev[i]) begin
        fails++; $display("FAIL addi cyc%0d: got %b want %b", i, outs(), ev[i]);
      end
      @(posedge Clk); #1;
    end
    exp_cnt++;
    tests++;
    if (InstrCount !== exp_cnt) begin
      fails++; $display("FAIL addi_count: got %0d want %0d", InstrCount, exp_cnt);
    end
  endtask

  task automatic test_jump();
    logic [17:0] ev [3] = '{EFetch, EDec, EJmp};
    Op = 6'b000010; Funct = 6'b0; MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (outs() !== ev[i]) begin
        fails++; $display("FAIL j cyc%0d: got %b want %b", i, outs(), ev[i]);
      end
      @(posedge Clk); #1;
    end
    exp_cnt++;
    tests++;
    if (InstrCount !== exp_cnt) begin
      fails++; $display("FAIL j_count: got %0d want %0d", InstrCount, exp_cnt);
    end
  endtask

  task automatic test_sw();
    logic [17:0] ev [5] = '{EFetch, EDec, EMAdr, EMWr, EMWrD};
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    Op = 6'b101011; Funct = 6'b0;
    for (int i = 0; i < 5; i++) begin
      MemReady = rd[i]; #1;
      tests++;
      if (outs() !== ev[i]) begin
        fails++; $display("FAIL sw cyc%0d: got %b want %b", i, outs(), ev[i]);
      end
      @(posedge Clk); #1;
    end
    exp_cnt++;
    tests++;
    if (InstrCount !== exp_cnt || MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL sw_after: cnt %0d memwrite %b, want cnt %0d memwrite 0",
               InstrCount, MemWrite, exp_cnt);
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] funct);
    logic [17:0] ev [3] = '{EFetch, EDIll, EFetch};
    Op = op; Funct = funct; MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (outs() !== ev[i]) begin
        fails++; $display("FAIL illegal_%b_%b cyc%0d: got %b want %b", op, funct, i, outs(), ev[i]);
      end
      if (i < 2) begin
        @(posedge Clk);
        #1;
      end
    end
    tests++;
    if (InstrCount !== exp_cnt) begin
      fails++; $display("FAIL illegal_count: got %0d want %0d", InstrCount, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [17:0] ev [5] = '{EFetch, EDec, EMAdr, EMWr, EMWr};
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    Op = 6'b101011; Funct = 6'b0;
    for (int i = 0; i < 5; i++) begin
      MemReady = rd[i]; #1;
      tests++;
      if (outs() !== ev[i]) begin
        fails++; $display("FAIL sw_rst cyc%0d: got %b want %b", i, outs(), ev[i]);
      end
      if (i == 4) Reset = 1'b1;
      @(posedge Clk); #1;
    end
    exp_cnt = 32'd0;
    tests++;
    if (outs() !== EIdle || InstrCount !== 32'd0) begin
      fails++;
      $display("FAIL sw_rst_idle: outs %b cnt %0d, want %b cnt 0", outs(), InstrCount, EIdle);
    end
    Reset = 1'b0; MemReady = 1'b1;
    @(posedge Clk); #1;
    tests++;
    if (outs() !== EFetch) begin
      fails++; $display("FAIL sw_rst_refetch: got %b want %b", outs(), EFetch);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype(6'b100000, 3'b010);
    test_rtype(6'b100010, 3'b110);
    test_rtype(6'b000000, 3'b011);
    test_rtype(6'b000100, 3'b100);
    test_rtype(6'b000111, 3'b101);
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi();
    test_jump();
    test_sw();
    test_illegal(6'b111111, 6'b000000);
    test_illegal(6'b000000, 6'b101010);
    test_reset_mid_sw();
    test_addi();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
